// File: rtl/bg_scene_sequencer_if.sv
// Interface bundling the per-frame control inputs, the host request handshake and
// the background selection/scroll/fade outputs of the scene sequencer.
interface bg_scene_sequencer_if #(
    parameter int NUM_BG = 4
);
    logic              vsync;
    logic              auto_en;
    logic              pause;
    logic              req_valid;
    logic [1:0]        req_bg;
    logic              req_ready;
    logic [NUM_BG-1:0] bg_en;
    logic [9:0]        scroll_x;
    logic [2:0]        twinkle;
    logic [1:0]        fade;
    logic              busy;

    modport master (
        output vsync, auto_en, pause, req_valid, req_bg,
        input  req_ready, bg_en, scroll_x, twinkle, fade, busy
    );

    modport slave (
        input  vsync, auto_en, pause, req_valid, req_bg,
        output req_ready, bg_en, scroll_x, twinkle, fade, busy
    );
endinterface

// File: rtl/bg_scene_sequencer.sv
// Frame-rate background sequencer: scroll/twinkle counters, dwell timer and a
// fade-out / switch / fade-in transition that moves the one-hot background enable.
module bg_scene_sequencer #(
    parameter int NUM_BG       = 4,
    parameter int DWELL_FRAMES = 600,
    parameter int FADE_FPS     = 4,
    parameter int SCROLL_STEP  = 5,
    parameter int H_RES        = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    bg_scene_sequencer_if.slave    bus
);
    localparam int DW = $clog2(DWELL_FRAMES);
    localparam int SW = (FADE_FPS > 1) ? $clog2(FADE_FPS) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_FRAMES - 1);
    localparam logic [SW-1:0] STEP_MAX  = SW'(FADE_FPS - 1);

    typedef enum logic [1:0] {S_SHOW, S_FADE_OUT, S_SWITCH, S_FADE_IN} state_t;

    state_t              r_state, w_state_next;
    logic [1:0]          r_cur, w_cur_next;
    logic [1:0]          r_target, w_target_next;
    logic [NUM_BG-1:0]   r_bg_en, w_bg_en_next;
    logic [9:0]          r_scroll, w_scroll_next;
    logic [2:0]          r_twinkle, w_twinkle_next;
    logic [1:0]          r_fade, w_fade_next;
    logic [DW-1:0]       r_dwell, w_dwell_next;
    logic [SW-1:0]       r_step, w_step_next;
    logic                r_vsync_q;

    logic                w_tick;
    logic                w_upd;
    logic                w_req_take;
    logic [1:0]          w_auto_bg;
    logic [10:0]         w_scroll_sum;
    logic [10:0]         w_scroll_wrap;
    logic [NUM_BG-1:0]   w_target_onehot;

    assign w_tick     = bus.vsync & ~r_vsync_q;
    assign w_upd      = w_tick & ~bus.pause;
    assign w_req_take = bus.req_valid && (r_state == S_SHOW) && (32'(bus.req_bg) < NUM_BG);
    assign w_auto_bg  = 2'((32'(r_cur) + 1) % NUM_BG);

    // Modulo add without a divider: one conditional subtract suffices since SCROLL_STEP < H_RES.
    assign w_scroll_sum  = {1'b0, r_scroll} + 11'(SCROLL_STEP);
    assign w_scroll_wrap = (w_scroll_sum >= 11'(H_RES)) ? (w_scroll_sum - 11'(H_RES)) : w_scroll_sum;

    generate
        for (genvar gi = 0; gi < NUM_BG; gi++) begin : g_onehot
            assign w_target_onehot[gi] = (r_target == 2'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_SHOW;
            r_cur     <= '0;
            r_target  <= '0;
            r_bg_en   <= NUM_BG'(1);
            r_scroll  <= '0;
            r_twinkle <= '0;
            r_fade    <= '0;
            r_dwell   <= '0;
            r_step    <= '0;
            r_vsync_q <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cur     <= w_cur_next;
            r_target  <= w_target_next;
            r_bg_en   <= w_bg_en_next;
            r_scroll  <= w_scroll_next;
            r_twinkle <= w_twinkle_next;
            r_fade    <= w_fade_next;
            r_dwell   <= w_dwell_next;
            r_step    <= w_step_next;
            r_vsync_q <= bus.vsync;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cur_next     = r_cur;
        w_target_next  = r_target;
        w_bg_en_next   = r_bg_en;
        w_scroll_next  = r_scroll;
        w_twinkle_next = r_twinkle;
        w_fade_next    = r_fade;
        w_dwell_next   = r_dwell;
        w_step_next    = r_step;

        if (w_upd) begin
            w_scroll_next  = w_scroll_wrap[9:0];
            w_twinkle_next = r_twinkle + 3'd1;
        end

        case (r_state)
            S_SHOW: begin
                // A host request takes priority over an auto-advance in the same cycle.
                if (w_req_take) begin
                    if (bus.req_bg == r_cur) begin
                        w_dwell_next = '0;
                    end else begin
                        w_target_next = bus.req_bg;
                        w_step_next   = '0;
                        w_state_next  = S_FADE_OUT;
                    end
                end else if (w_upd) begin
                    if (r_dwell != DWELL_MAX) begin
                        w_dwell_next = r_dwell + 1'b1;
                    end else if (bus.auto_en) begin
                        w_target_next = w_auto_bg;
                        w_step_next   = '0;
                        w_state_next  = S_FADE_OUT;
                    end
                end
            end
            S_FADE_OUT: begin
                if (w_upd) begin
                    if (r_step == STEP_MAX) begin
                        w_step_next = '0;
                        w_fade_next = r_fade + 2'd1;
                        if (r_fade == 2'd2) w_state_next = S_SWITCH;
                    end else begin
                        w_step_next = r_step + 1'b1;
                    end
                end
            end
            S_SWITCH: begin
                w_cur_next    = r_target;
                w_bg_en_next  = w_target_onehot;
                w_scroll_next = '0;
                w_dwell_next  = '0;
                w_step_next   = '0;
                w_state_next  = S_FADE_IN;
            end
            S_FADE_IN: begin
                if (w_upd) begin
                    if (r_step == STEP_MAX) begin
                        w_step_next = '0;
                        w_fade_next = r_fade - 2'd1;
                        if (r_fade == 2'd1) w_state_next = S_SHOW;
                    end else begin
                        w_step_next = r_step + 1'b1;
                    end
                end
            end
            default: w_state_next = S_SHOW;
        endcase
    end

    assign bus.req_ready = (r_state == S_SHOW);
    assign bus.busy      = (r_state != S_SHOW);
    assign bus.bg_en     = r_bg_en;
    assign bus.scroll_x  = r_scroll;
    assign bus.twinkle   = r_twinkle;
    assign bus.fade      = r_fade;
endmodule

// File: tb/tb_bg_scene_sequencer.sv
// Directed bench for bg_scene_sequencer: vector table for free-run and auto-advance
// sequences, plus hand-written request, priority, pause and async-reset sequences.
module tb_bg_scene_sequencer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    bg_scene_sequencer_if #(.NUM_BG(4)) bus ();

    bg_scene_sequencer #(
        .NUM_BG(4), .DWELL_FRAMES(8), .FADE_FPS(2), .SCROLL_STEP(5), .H_RES(1024)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         do_reset;
        int         n_ticks;
        logic       auto_en;
        logic [9:0] scroll;
        logic [2:0] twinkle;
        logic [3:0] bg_en;
        logic [1:0] fade;
        logic       busy;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        bus.vsync = 1'b0; bus.req_valid = 1'b0; bus.req_bg = 2'd0;
        bus.pause = 1'b0; bus.auto_en = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    // One vsync pulse; returns on a falling edge with one idle cycle after the tick edge.
    task automatic pulse();
        @(negedge clk); bus.vsync = 1'b1;
        @(negedge clk); bus.vsync = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) pulse();
    endtask

    task automatic request(input logic [1:0] bg, input string name, input logic ready_req);
        @(negedge clk); bus.req_valid = 1'b1; bus.req_bg = bg;
        #1 check({name, ".req_ready"}, 32'(bus.req_ready), 32'(ready_req));
        @(negedge clk); bus.req_valid = 1'b0;
    endtask

    initial begin
        int errs;
        logic [9:0] exp_s;
        n_cmp = 0; n_bad = 0;
        rst = 1'b0;
        bus.vsync = 1'b0; bus.auto_en = 1'b0; bus.pause = 1'b0;
        bus.req_valid = 1'b0; bus.req_bg = 2'd0;

        //            rst ticks auto scroll tw bg      fade busy
        vecs[0]  = '{1, 0,  0, 10'd0,  3'd0, 4'b0001, 2'd0, 0};
        vecs[1]  = '{0, 10, 0, 10'd50, 3'd2, 4'b0001, 2'd0, 0};
        vecs[2]  = '{1, 7,  1, 10'd35, 3'd7, 4'b0001, 2'd0, 0};
        vecs[3]  = '{0, 1,  1, 10'd40, 3'd0, 4'b0001, 2'd0, 1};
        vecs[4]  = '{0, 2,  1, 10'd50, 3'd2, 4'b0001, 2'd1, 1};
        vecs[5]  = '{0, 2,  1, 10'd60, 3'd4, 4'b0001, 2'd2, 1};
        vecs[6]  = '{0, 2,  1, 10'd0,  3'd6, 4'b0010, 2'd3, 1};
        vecs[7]  = '{0, 2,  1, 10'd10, 3'd0, 4'b0010, 2'd2, 1};
        vecs[8]  = '{0, 2,  1, 10'd20, 3'd2, 4'b0010, 2'd1, 1};
        vecs[9]  = '{0, 2,  1, 10'd30, 3'd4, 4'b0010, 2'd0, 0};
        vecs[10] = '{0, 1,  1, 10'd35, 3'd5, 4'b0010, 2'd0, 0};

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].do_reset) do_reset();
            bus.auto_en = vecs[i].auto_en;
            pulses(vecs[i].n_ticks);
            $display("vec %0d: ticks=%0d auto=%0b -> scroll=%0d tw=%0d bg=%b fade=%0d busy=%0b",
                     i, vecs[i].n_ticks, vecs[i].auto_en, bus.scroll_x, bus.twinkle,
                     bus.bg_en, bus.fade, bus.busy);
            check($sformatf("vec%0d.scroll", i),  32'(bus.scroll_x), 32'(vecs[i].scroll));
            check($sformatf("vec%0d.twinkle", i), 32'(bus.twinkle),  32'(vecs[i].twinkle));
            check($sformatf("vec%0d.bg_en", i),   32'(bus.bg_en),    32'(vecs[i].bg_en));
            check($sformatf("vec%0d.fade", i),    32'(bus.fade),     32'(vecs[i].fade));
            check($sformatf("vec%0d.busy", i),    32'(bus.busy),     32'(vecs[i].busy));
        end

        // vsync held high for 20 cycles is a single tick
        do_reset();
        pulses(10);
        @(negedge clk); bus.vsync = 1'b1;
        repeat (20) @(negedge clk);
        bus.vsync = 1'b0;
        @(negedge clk);
        $display("held vsync: scroll=%0d tw=%0d", bus.scroll_x, bus.twinkle);
        check("held.scroll", 32'(bus.scroll_x), 32'd55);
        check("held.twinkle", 32'(bus.twinkle), 32'd3);

        // 205 ticks from reset: scroll tracks (5*k) mod 1024, ends at 1
        do_reset();
        errs = 0; exp_s = 10'd0;
        for (int k = 1; k <= 205; k++) begin
            pulse();
            exp_s = (exp_s + 10'd5 >= 10'd0 && {1'b0, exp_s} + 11'd5 >= 11'd1024)
                    ? 10'({1'b0, exp_s} + 11'd5 - 11'd1024) : exp_s + 10'd5;
            if (bus.scroll_x !== exp_s) errs++;
        end
        $display("wrap run: scroll=%0d tw=%0d tracking_errs=%0d", bus.scroll_x, bus.twinkle, errs);
        check("wrap.track_errs", 32'(errs), 32'd0);
        check("wrap.scroll", 32'(bus.scroll_x), 32'd1);
        check("wrap.twinkle", 32'(bus.twinkle), 32'd5);
        check("wrap.busy", 32'(bus.busy), 32'd0);

        // Host request to bg 3, drop during FADE_IN, then same-bg restart of dwell
        do_reset();
        request(2'd3, "req3", 1'b1);
        $display("req bg3: busy=%0b", bus.busy);
        check("req3.busy", 32'(bus.busy), 32'd1);
        pulses(6);
        check("req3.bg_en", 32'(bus.bg_en), 32'b1000);
        request(2'd1, "drop", 1'b0);
        pulses(6);
        $display("after fade-in: bg=%b busy=%0b fade=%0d", bus.bg_en, bus.busy, bus.fade);
        check("drop.bg_en", 32'(bus.bg_en), 32'b1000);
        check("drop.busy", 32'(bus.busy), 32'd0);
        bus.auto_en = 1'b1;
        pulses(5);
        request(2'd3, "same", 1'b1);
        check("same.busy", 32'(bus.busy), 32'd0);
        pulses(7);
        $display("same-bg restart: busy after 7 ticks=%0b", bus.busy);
        check("same.busy_7", 32'(bus.busy), 32'd0);
        pulse();
        check("same.busy_8", 32'(bus.busy), 32'd1);

        // Request on the same edge as auto-expiry wins
        do_reset();
        bus.auto_en = 1'b1;
        pulses(7);
        @(negedge clk); bus.vsync = 1'b1; bus.req_valid = 1'b1; bus.req_bg = 2'd2;
        @(negedge clk); bus.vsync = 1'b0; bus.req_valid = 1'b0;
        check("prio.busy", 32'(bus.busy), 32'd1);
        pulses(6);
        $display("priority: bg=%b", bus.bg_en);
        check("prio.bg_en", 32'(bus.bg_en), 32'b0100);

        // Pause mid FADE_OUT, then async reset mid FADE_IN
        do_reset();
        request(2'd1, "pause_req", 1'b1);
        pulses(2);
        check("pause.pre_fade", 32'(bus.fade), 32'd1);
        bus.pause = 1'b1;
        pulses(5);
        $display("paused: fade=%0d scroll=%0d tw=%0d", bus.fade, bus.scroll_x, bus.twinkle);
        check("pause.fade", 32'(bus.fade), 32'd1);
        check("pause.scroll", 32'(bus.scroll_x), 32'd10);
        check("pause.twinkle", 32'(bus.twinkle), 32'd2);
        check("pause.busy", 32'(bus.busy), 32'd1);
        bus.pause = 1'b0;
        pulses(4);
        check("pause.bg_en", 32'(bus.bg_en), 32'b0010);
        pulses(2);
        check("pause.fadein", 32'(bus.fade), 32'd2);
        @(negedge clk); rst = 1'b1;
        #1;
        $display("async reset: bg=%b scroll=%0d tw=%0d fade=%0d busy=%0b ready=%0b",
                 bus.bg_en, bus.scroll_x, bus.twinkle, bus.fade, bus.busy, bus.req_ready);
        check("arst.bg_en", 32'(bus.bg_en), 32'b0001);
        check("arst.scroll", 32'(bus.scroll_x), 32'd0);
        check("arst.twinkle", 32'(bus.twinkle), 32'd0);
        check("arst.fade", 32'(bus.fade), 32'd0);
        check("arst.busy", 32'(bus.busy), 32'd0);
        check("arst.ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
